// File: rtl/aemb2_sfrs.sv
// aemb2_sfrs -- special-function registers for the AEMB2 core.
//
// Holds the MSR (two banks selected by gpha when AEMB_HTX=1) and optionally
// the EAR. It executes mts/mfs/msrset/msrclr, tracks carry/break/interrupt
// state, and arbitrates the external interrupt through a small FSM.
//
// Optional feature: define AEMB2_SFR_EAR_EN to build the 32-bit EAR at SFR
// select 0x0003. Without it that select reads 0 and drops writes.
//
// Ports:
//   gclk, grst        clock; asynchronous active-low reset
//   dena              pipeline enable (synchroniser clocks regardless)
//   gpha              thread phase / MSR bank select
//   mts_ex, mfs_ex    SFR move-to / move-from in EX
//   msr_set_ex/_clr_ex msrset / msrclr in EX
//   imm_ex[15:0]      SFR select (mts/mfs) or bit mask (msrset/msrclr)
//   opa_ex[31:0]      mts source data
//   rpc_ex[29:0]      word PC of the EX instruction
//   cry_we, cry_ex    ALU carry update
//   ret_ex[1:0]       00 none, 01 rtid, 10 rtbd, 11 rted
//   brk_ex            brk/brki executed
//   sys_int           asynchronous level interrupt
//   int_ack           fetch has vectored the interrupt
//   sfr_mx[31:0]      registered SFR read data (MX stage)
//   msr_cc/ie/bip/ice/dce  MSR status of the current bank
//   int_req           interrupt request to fetch
//
// Interrupt FSM:
//   state | meaning
//   IDLE  | no interrupt outstanding
//   PEND  | request raised, waiting for fetch to vector it
//   SERV  | handler running, waiting for rtid
module aemb2_sfrs #(
  parameter int AEMB_HTX = 1
) (
  input  logic        gclk,
  input  logic        grst,
  input  logic        dena,
  input  logic        gpha,
  input  logic        mts_ex,
  input  logic        mfs_ex,
  input  logic        msr_set_ex,
  input  logic        msr_clr_ex,
  input  logic [15:0] imm_ex,
  input  logic [31:0] opa_ex,
  input  logic [29:0] rpc_ex,
  input  logic        cry_we,
  input  logic        cry_ex,
  input  logic [1:0]  ret_ex,
  input  logic        brk_ex,
  input  logic        sys_int,
  input  logic        int_ack,
  output logic [31:0] sfr_mx,
  output logic        msr_cc,
  output logic        msr_ie,
  output logic        msr_bip,
  output logic        msr_ice,
  output logic        msr_dce,
  output logic        int_req
);

  // Compact MSR storage: only the mapped bits are kept.
  localparam int B_IE  = 0;
  localparam int B_C   = 1;
  localparam int B_BIP = 2;
  localparam int B_ICE = 3;
  localparam int B_DCE = 4;

  typedef enum logic [1:0] {IDLE, PEND, SERV} int_state_e;

  function automatic logic [31:0] msr_word(input logic [4:0] m);
    return {m[B_C], 23'd0, m[B_DCE], 1'b0, m[B_ICE], 1'b0,
            m[B_BIP], m[B_C], m[B_IE], 1'b0};
  endfunction

  logic [4:0]  msr_q [2];
  logic [4:0]  msr_d [2];
  logic [31:0] sfr_mx_q, sfr_mx_d;
  logic [1:0]  sync_q;
  int_state_e  state_q, state_d;

  logic        bank_sel;
  logic [4:0]  msr_cur, msr_nxt;
  logic [4:0]  imm_bits, opa_bits;
  logic [31:0] rd_data;
  logic        sel_pc, sel_msr, sel_ear;
  logic        sint, int_take;
  logic        unused_opa;

  assign unused_opa = ^opa_ex;

  assign bank_sel = (AEMB_HTX != 0) ? gpha : 1'b0;
  assign msr_cur  = msr_q[bank_sel];
  assign sint     = sync_q[1];

  assign sel_pc   = (imm_ex == 16'h0000);
  assign sel_msr  = (imm_ex == 16'h0001);
  assign sel_ear  = (imm_ex == 16'h0003);

  assign imm_bits = {imm_ex[7], imm_ex[5], imm_ex[3], imm_ex[2], imm_ex[1]};
  assign opa_bits = {opa_ex[7], opa_ex[5], opa_ex[3], opa_ex[2], opa_ex[1]};

  assign int_take = dena && (state_q == PEND) && int_ack;

`ifdef AEMB2_SFR_EAR_EN
  logic [31:0] ear_q, ear_d;

  always_comb begin
    ear_d = ear_q;
    if (dena && mts_ex && sel_ear) ear_d = opa_ex;
  end

  always_ff @(posedge gclk or negedge grst) begin
    if (!grst) ear_q <= 32'd0;
    else       ear_q <= ear_d;
  end
`endif

  // Updates are applied lowest priority first so that a higher-priority
  // operation overrides only the bits it actually touches.
  always_comb begin
    msr_nxt = msr_cur;
    if (cry_we)   msr_nxt[B_C]   = cry_ex;
    if (int_take) msr_nxt[B_IE]  = 1'b0;
    if (brk_ex)   msr_nxt[B_BIP] = 1'b1;
    case (ret_ex)
      2'b01:   msr_nxt[B_IE]  = 1'b1;
      2'b10:   msr_nxt[B_BIP] = 1'b0;
      default: ;
    endcase
    if (mts_ex && sel_msr) msr_nxt = opa_bits;
    if (msr_set_ex)        msr_nxt = msr_nxt | imm_bits;
    if (msr_clr_ex)        msr_nxt = msr_nxt & ~imm_bits;

    msr_d = msr_q;
    if (dena) msr_d[bank_sel] = msr_nxt;
  end

  always_comb begin
    rd_data = 32'd0;
    if (sel_pc)       rd_data = {rpc_ex, 2'b00};
    else if (sel_msr) rd_data = msr_word(msr_cur);
`ifdef AEMB2_SFR_EAR_EN
    else if (sel_ear) rd_data = ear_q;
`endif

    sfr_mx_d = sfr_mx_q;
    if (dena) begin
      if (mfs_ex)                        sfr_mx_d = rd_data;
      else if (msr_set_ex || msr_clr_ex) sfr_mx_d = msr_word(msr_cur);
      else                               sfr_mx_d = 32'd0;
    end
  end

  always_comb begin
    state_d = state_q;
    if (dena) begin
      case (state_q)
        IDLE: if (sint && msr_cur[B_IE] && !msr_cur[B_BIP]) state_d = PEND;
        PEND: begin
          if (int_ack)   state_d = SERV;
          else if (!sint) state_d = IDLE;
        end
        SERV: if (ret_ex == 2'b01) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge gclk or negedge grst) begin
    if (!grst) begin
      msr_q[0] <= 5'd0;
      msr_q[1] <= 5'd0;
      sfr_mx_q <= 32'd0;
      sync_q   <= 2'b00;
      state_q  <= IDLE;
    end else begin
      msr_q    <= msr_d;
      sfr_mx_q <= sfr_mx_d;
      sync_q   <= {sync_q[0], sys_int};
      state_q  <= state_d;
    end
  end

  assign sfr_mx  = sfr_mx_q;
  assign msr_cc  = msr_cur[B_C];
  assign msr_ie  = msr_cur[B_IE];
  assign msr_bip = msr_cur[B_BIP];
  assign msr_ice = msr_cur[B_ICE];
  assign msr_dce = msr_cur[B_DCE];
  assign int_req = (state_q == PEND);

endmodule

// File: tb/tb_aemb2_sfrs.sv
module tb_aemb2_sfrs;

  localparam int S_SFR = 0;
  localparam int S_CC  = 1;
  localparam int S_IE  = 2;
  localparam int S_BIP = 3;
  localparam int S_ICE = 4;
  localparam int S_DCE = 5;
  localparam int S_IRQ = 6;

`ifdef AEMB2_SFR_EAR_EN
  localparam logic [31:0] EAR_EXP = 32'hDEADBEEF;
`else
  localparam logic [31:0] EAR_EXP = 32'h00000000;
`endif

  logic        gclk = 1'b0;
  logic        grst = 1'b0;
  logic        dena, gpha, mts_ex, mfs_ex, msr_set_ex, msr_clr_ex;
  logic [15:0] imm_ex;
  logic [31:0] opa_ex;
  logic [29:0] rpc_ex;
  logic        cry_we, cry_ex, brk_ex, sys_int, int_ack;
  logic [1:0]  ret_ex;
  logic [31:0] sfr_mx;
  logic        msr_cc, msr_ie, msr_bip, msr_ice, msr_dce, int_req;

  aemb2_sfrs #(.AEMB_HTX(1)) dut (
    .gclk(gclk), .grst(grst), .dena(dena), .gpha(gpha),
    .mts_ex(mts_ex), .mfs_ex(mfs_ex), .msr_set_ex(msr_set_ex), .msr_clr_ex(msr_clr_ex),
    .imm_ex(imm_ex), .opa_ex(opa_ex), .rpc_ex(rpc_ex),
    .cry_we(cry_we), .cry_ex(cry_ex), .ret_ex(ret_ex), .brk_ex(brk_ex),
    .sys_int(sys_int), .int_ack(int_ack),
    .sfr_mx(sfr_mx), .msr_cc(msr_cc), .msr_ie(msr_ie), .msr_bip(msr_bip),
    .msr_ice(msr_ice), .msr_dce(msr_dce), .int_req(int_req)
  );

  always #5 gclk = ~gclk;

  int cyc = 0;
  always @(posedge gclk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    int          sig;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        keep_q[$];
  logic [31:0] act;
  int          n_tests = 0;
  int          n_fail  = 0;

  function automatic logic [31:0] sig_val(input int sig);
    case (sig)
      S_SFR:   return sfr_mx;
      S_CC:    return {31'd0, msr_cc};
      S_IE:    return {31'd0, msr_ie};
      S_BIP:   return {31'd0, msr_bip};
      S_ICE:   return {31'd0, msr_ice};
      S_DCE:   return {31'd0, msr_dce};
      default: return {31'd0, int_req};
    endcase
  endfunction

  task automatic expect_at(input int dly, input int sig, input logic [31:0] v, input string nm);
    exp_t e;
    e.due  = cyc + dly;
    e.sig  = sig;
    e.exp  = v;
    e.name = nm;
    sb_q.push_back(e);
  endtask

  // Monitor: DUT outputs are presented every cycle; compare any entry due now.
  always @(negedge gclk) begin
    keep_q = {};
    foreach (sb_q[i]) begin
      if (sb_q[i].due <= cyc) begin
        act = sig_val(sb_q[i].sig);
        n_tests++;
        if (act !== sb_q[i].exp) begin
          n_fail++;
          $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)",
                   sb_q[i].name, act, sb_q[i].exp, cyc);
        end
      end else begin
        keep_q.push_back(sb_q[i]);
      end
    end
    sb_q = keep_q;
  end

  task automatic clr();
    mts_ex = 0; mfs_ex = 0; msr_set_ex = 0; msr_clr_ex = 0;
    cry_we = 0; cry_ex = 0; ret_ex = 2'b00; brk_ex = 0; int_ack = 0;
    imm_ex = 16'h0000; opa_ex = 32'h0;
  endtask

  task automatic tick();
    @(posedge gclk);
    #1;
    clr();
  endtask

  initial begin
    clr();
    dena = 1; gpha = 0; sys_int = 0; rpc_ex = 30'h0;
    repeat (3) @(posedge gclk);
    #1 grst = 1;

    expect_at(0, S_SFR, 32'h0, "rst_sfr");
    expect_at(0, S_CC,  32'h0, "rst_cc");
    expect_at(0, S_IE,  32'h0, "rst_ie");
    expect_at(0, S_BIP, 32'h0, "rst_bip");
    expect_at(0, S_ICE, 32'h0, "rst_ice");
    expect_at(0, S_DCE, 32'h0, "rst_dce");
    expect_at(0, S_IRQ, 32'h0, "rst_irq");
    mfs_ex = 1; imm_ex = 16'h0001;
    expect_at(1, S_SFR, 32'h0, "mfs_msr_rst");
    tick();

    msr_set_ex = 1; imm_ex = 16'h00A2;
    expect_at(1, S_SFR, 32'h0, "msrset_old");
    tick();

    mfs_ex = 1; imm_ex = 16'h0001;
    expect_at(1, S_SFR, 32'h000000A2, "mfs_a2");
    expect_at(0, S_IE,  32'h1, "set_ie");
    expect_at(0, S_ICE, 32'h1, "set_ice");
    expect_at(0, S_DCE, 32'h1, "set_dce");
    expect_at(0, S_CC,  32'h0, "set_cc_untouched");
    tick();

    msr_set_ex = 1; imm_ex = 16'h0004;
    expect_at(1, S_SFR, 32'h000000A2, "msrset_c_old");
    tick();

    mfs_ex = 1; imm_ex = 16'h0001;
    expect_at(1, S_SFR, 32'h800000A6, "mfs_with_cc");
    expect_at(0, S_CC,  32'h1, "set_cc");
    tick();

    msr_clr_ex = 1; imm_ex = 16'h0004; cry_we = 1; cry_ex = 1;
    expect_at(1, S_SFR, 32'h800000A6, "msrclr_old");
    tick();

    mfs_ex = 1; imm_ex = 16'h0000; rpc_ex = 30'h400;
    expect_at(1, S_SFR, 32'h00001000, "mfs_pc");
    expect_at(0, S_CC,  32'h0, "clr_beats_cry");
    tick();

    mfs_ex = 1; imm_ex = 16'h0001; cry_we = 1; cry_ex = 1;
    expect_at(1, S_SFR, 32'h000000A2, "mfs_before_cry");
    tick();

    msr_clr_ex = 1; imm_ex = 16'h00A6;
    expect_at(1, S_SFR, 32'h800000A6, "msrclr_all_old");
    expect_at(0, S_CC,  32'h1, "cry_set");
    tick();

    mfs_ex = 1; imm_ex = 16'h0001;
    expect_at(1, S_SFR, 32'h0, "mfs_cleared");
    expect_at(0, S_IE,  32'h0, "clr_ie");
    tick();

    mts_ex = 1; imm_ex = 16'h0001; opa_ex = 32'hFFFFFFFF;
    expect_at(1, S_SFR, 32'h0, "mts_sfr_zero");
    tick();

    mfs_ex = 1; imm_ex = 16'h0001;
    expect_at(1, S_SFR, 32'h800000AE, "mts_mapped");
    expect_at(0, S_BIP, 32'h1, "mts_bip");
    tick();

    mfs_ex = 1; imm_ex = 16'h0002;
    expect_at(1, S_SFR, 32'h0, "mfs_unmapped");
    tick();

    mts_ex = 1; imm_ex = 16'h0001; opa_ex = 32'h00000002;
    tick();

    // Interrupt: 2-flop synchroniser then FSM register.
    expect_at(0, S_IE,  32'h1, "mts_ie");
    expect_at(0, S_BIP, 32'h0, "mts_bip_clr");
    sys_int = 1;
    expect_at(2, S_IRQ, 32'h0, "irq_sync_lat");
    expect_at(3, S_IRQ, 32'h1, "irq_req");
    tick(); tick(); tick();

    int_ack = 1;
    expect_at(1, S_IRQ, 32'h0, "ack_drop");
    expect_at(1, S_IE,  32'h0, "ack_clr_ie");
    tick();

    int_ack = 1;
    expect_at(1, S_IRQ, 32'h0, "ack_in_serv");
    expect_at(1, S_IE,  32'h0, "ack_in_serv_ie");
    tick();

    ret_ex = 2'b01;
    expect_at(1, S_IE,  32'h1, "rtid_ie");
    expect_at(1, S_IRQ, 32'h0, "rtid_idle");
    expect_at(2, S_IRQ, 32'h1, "irq_reassert");
    tick(); tick();

    sys_int = 0;
    expect_at(2, S_IRQ, 32'h1, "pend_hold");
    expect_at(3, S_IRQ, 32'h0, "pend_abort");
    expect_at(3, S_IE,  32'h1, "abort_ie");
    tick(); tick(); tick();

    sys_int = 1;
    expect_at(3, S_IRQ, 32'h1, "irq_again");
    tick(); tick(); tick();

    int_ack = 1; msr_set_ex = 1; imm_ex = 16'h0002; sys_int = 0;
    expect_at(1, S_IE,  32'h1, "set_beats_ack");
    expect_at(1, S_IRQ, 32'h0, "set_ack_drop");
    expect_at(2, S_IRQ, 32'h0, "serv_hold");
    tick(); tick();

    ret_ex = 2'b01;
    tick();

    // Banked MSR.
    msr_clr_ex = 1; imm_ex = 16'h0002;
    tick();
    msr_set_ex = 1; imm_ex = 16'h0002;
    expect_at(0, S_IE, 32'h0, "b0_ie_clr");
    tick();
    expect_at(0, S_IE, 32'h1, "b0_ie");
    tick();
    gpha = 1; brk_ex = 1;
    expect_at(0, S_IE, 32'h0, "b1_ie");
    tick();
    gpha = 1; mfs_ex = 1; imm_ex = 16'h0001;
    expect_at(0, S_BIP, 32'h1, "b1_bip");
    expect_at(1, S_SFR, 32'h00000008, "b1_mfs");
    tick();
    gpha = 0;
    expect_at(0, S_BIP, 32'h0, "b0_bip");
    tick();
    gpha = 1; ret_ex = 2'b10;
    expect_at(1, S_BIP, 32'h0, "rtbd");
    tick();

    // EAR and pipeline enable.
    gpha = 0; mts_ex = 1; imm_ex = 16'h0003; opa_ex = 32'hDEADBEEF;
    tick();
    mfs_ex = 1; imm_ex = 16'h0003;
    expect_at(1, S_SFR, EAR_EXP, "ear_rd");
    tick();
    dena = 0; msr_set_ex = 1; imm_ex = 16'h0080;
    expect_at(1, S_SFR, EAR_EXP, "dena_hold");
    expect_at(1, S_DCE, 32'h0, "dena_no_upd");
    tick();
    dena = 1;
    tick(); tick();

    if (sb_q.size() != 0) begin
      n_fail += sb_q.size();
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
